// File: rtl/dmem_if.sv
// Load/store handshake bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport slave (
        input  req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one RV32I load/store at a time, programmable wait states,
// byte/half/word access with extension, error flag for misaligned/out-of-range/illegal requests.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic  clk_i,
    input  logic  reset_i,
    dmem_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [2:0] WS     = 3'(WAIT_STATES);
    localparam int         DEPTH  = 1 << ADDR_WIDTH;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic        r_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rdata;
    logic        r_err;
    req_t        r_req;
    logic [31:0] r_mem [DEPTH];

    req_t                  w_in;
    req_t                  w_req;
    logic                  w_accept;
    logic                  w_access;
    logic [1:0]            w_lane;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_oor;
    logic                  w_misal;
    logic                  w_illegal;
    logic                  w_err;
    logic [31:0]           w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;
    logic [31:0]           w_rsp_rdata;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata_sh;
    logic                  w_we;

    assign w_in = '{write:  bus.req_write_i,
                    funct3: bus.req_funct3_i,
                    addr:   bus.req_addr_i,
                    wdata:  bus.req_wdata_i};

    // With zero wait states the access happens on the accepting edge, so it must
    // see the live request rather than the not-yet-captured copy.
    assign w_req    = (r_state == S_IDLE) ? w_in : r_req;
    assign w_accept = (r_state == S_IDLE) && r_ready && bus.req_valid_i;
    assign w_access = (WAIT_STATES == 0) ? w_accept
                                         : ((r_state == S_WAIT) && (r_cnt == 3'd1));

    assign w_lane    = w_req.addr[1:0];
    assign w_idx     = w_req.addr[ADDR_WIDTH+1:2];
    assign w_oor     = |w_req.addr[31:ADDR_WIDTH+2];
    assign w_misal   = ((w_req.funct3[1:0] == 2'd1) && w_lane[0]) ||
                       ((w_req.funct3[1:0] == 2'd2) && (w_lane != 2'd0));
    assign w_illegal = w_req.write ? (w_req.funct3 > 3'd2)
                                   : ((w_req.funct3 == 3'd3) || (w_req.funct3 > 3'd5));
    assign w_err     = w_oor | w_misal | w_illegal;

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[8*w_lane +: 8];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = 32'd0;
        case (w_req.funct3)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_load = {24'd0, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd5:    w_load = {16'd0, w_half};
            3'd2:    w_load = w_word;
            default: w_load = 32'd0;
        endcase
    end

    assign w_rsp_rdata = (w_err || w_req.write) ? 32'd0 : w_load;

    always_comb begin
        w_be = 4'b0000;
        case (w_req.funct3)
            3'd0:    w_be = 4'b0001 << w_lane;
            3'd1:    w_be = 4'b0011 << w_lane;
            3'd2:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_wdata_sh = w_req.wdata << {w_lane, 3'b000};
    assign w_we       = w_access && w_req.write && !w_err;

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
            r_req       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_req   <= w_in;
                        if (WAIT_STATES != 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= WS;
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_state     <= S_IDLE;
                        r_ready     <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rdata     <= 32'd0;
                        r_err       <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_access) begin
                r_state     <= S_RESP;
                r_rsp_valid <= 1'b1;
                r_rdata     <= w_rsp_rdata;
                r_err       <= w_err;
            end
        end
    end

    assign bus.req_ready_o = r_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rdata;
    assign bus.rsp_err_o   = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed plan plus random traffic against a byte-level memory model.
module tb_dmem_responder;
    localparam int AW = 10;
    localparam int WS = 2;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;

    dmem_if bus();

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [int];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          hs_cyc = -1;
    int          rdy_mode = 0;
    logic        prev_valid = 1'b0;

    always @(posedge clk_i) cyc++;

    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            0:       bus.rsp_ready_i = ($urandom_range(3) != 0);
            1:       bus.rsp_ready_i = 1'b0;
            default: bus.rsp_ready_i = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: bytes picked out of a word by arithmetic, extension by masking.
    function automatic void model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int          size, lane, bits;
        bit          illegal;
        logic [31:0] word, val, mask;
        rd      = 32'd0;
        lane    = int'(a % 4);
        illegal = wr ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size    = 1 << f3[1:0];
        err     = illegal || (a >= 32'(4 << AW)) || (!illegal && (lane % size) != 0);
        if (err) return;
        word = model_mem.exists(int'(a / 4)) ? model_mem[int'(a / 4)] : 32'd0;
        if (wr) begin
            for (int i = 0; i < size; i++) word[8*(lane+i) +: 8] = wd[8*i +: 8];
            model_mem[int'(a / 4)] = word;
        end else begin
            bits = 8 * size;
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
            val  = (word >> (8 * lane)) & mask;
            if (f3 < 3'd4 && size < 4 && val[bits-1]) val = val | ~mask;
            rd = val;
        end
    endfunction

    task automatic issue(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit track, output int acc);
        exp_t e;
        bit   rdy;
        int   guard = 0;
        @(negedge clk_i);
        bus.req_valid_i  = 1'b1;
        bus.req_write_i  = wr;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = a;
        bus.req_wdata_i  = wd;
        rdy = bus.req_ready_o;
        @(posedge clk_i); #1;
        while (!rdy && guard < 200) begin
            rdy = bus.req_ready_o;
            @(posedge clk_i); #1;
            guard++;
        end
        acc = cyc;
        bus.req_valid_i = 1'b0;
        if (!rdy) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: request at %h never accepted, want acceptance", a);
        end else if (track) begin
            model(wr, f3, a, wd, e.rdata, e.err);
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(posedge clk_i);
            g++;
        end
        if (sb.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, want 0", sb.size());
            sb.delete();
        end
        @(negedge clk_i);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (!reset_i) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.rsp_valid_o && !prev_valid && sb.size() != 0)
                chk("latency", 32'(cyc), 32'(sb[0].acc + WS));
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                if (sb.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL spurious_rsp: got response %h, want none", bus.rsp_rdata_o);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", bus.rsp_rdata_o, e.rdata);
                    chk("err", {31'd0, bus.rsp_err_o}, {31'd0, e.err});
                    hs_cyc = cyc + 1;
                end
            end
            prev_valid = bus.rsp_valid_o;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc, prev, g;
        logic [31:0] snap, a;
        bit          wr;
        logic [2:0]  f3;
        bus.req_valid_i  = 1'b0;
        bus.req_write_i  = 1'b0;
        bus.req_funct3_i = 3'd0;
        bus.req_addr_i   = 32'd0;
        bus.req_wdata_i  = 32'd0;
        bus.rsp_ready_i  = 1'b0;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        chk("rst_rdata", bus.rsp_rdata_o, 32'd0);
        chk("rst_err", {31'd0, bus.rsp_err_o}, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        #1 chk("ready_before_edge", {31'd0, bus.req_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("ready_after_edge", {31'd0, bus.req_ready_o}, 32'd1);

        // Reset abort of an in-flight store
        issue(1, 3'd2, 32'h100, 32'h1122_3344, 1, acc);
        drain();
        issue(1, 3'd2, 32'h100, 32'hDEAD_BEEF, 0, acc);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("abort_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
        chk("abort_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        chk("abort_rdata", bus.rsp_rdata_o, 32'd0);
        chk("abort_err", {31'd0, bus.rsp_err_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        issue(0, 3'd2, 32'h100, 32'd0, 1, acc);
        drain();

        // Extension, partial stores, errors
        issue(1, 3'd2, 32'h40, 32'h8899_AABB, 1, acc);
        issue(0, 3'd0, 32'h43, 32'd0, 1, acc);
        issue(0, 3'd4, 32'h43, 32'd0, 1, acc);
        issue(0, 3'd1, 32'h42, 32'd0, 1, acc);
        issue(0, 3'd5, 32'h40, 32'd0, 1, acc);
        issue(0, 3'd2, 32'h40, 32'd0, 1, acc);
        issue(1, 3'd0, 32'h41, 32'hFFFF_FFCC, 1, acc);
        issue(0, 3'd2, 32'h40, 32'd0, 1, acc);
        issue(1, 3'd1, 32'h42, 32'h0000_1234, 1, acc);
        issue(0, 3'd2, 32'h40, 32'd0, 1, acc);
        issue(0, 3'd2, 32'h42, 32'd0, 1, acc);
        issue(1, 3'd1, 32'h43, 32'h0000_FFFF, 1, acc);
        issue(0, 3'd2, 32'h40, 32'd0, 1, acc);
        issue(0, 3'd2, 32'h1000, 32'd0, 1, acc);
        issue(0, 3'd3, 32'h40, 32'd0, 1, acc);
        issue(1, 3'd4, 32'h40, 32'h5555_5555, 1, acc);
        issue(0, 3'd2, 32'h40, 32'd0, 1, acc);
        drain();

        // Backpressure with a queued request
        rdy_mode = 1;
        issue(0, 3'd2, 32'h40, 32'd0, 1, acc);
        g = 0;
        while (!bus.rsp_valid_o && g < 50) begin
            @(negedge clk_i);
            g++;
        end
        chk("bp_valid_seen", {31'd0, bus.rsp_valid_o}, 32'd1);
        bus.req_valid_i  = 1'b1;
        bus.req_write_i  = 1'b0;
        bus.req_funct3_i = 3'd4;
        bus.req_addr_i   = 32'h41;
        snap = bus.rsp_rdata_o;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
            chk("bp_rdata", bus.rsp_rdata_o, snap);
            chk("bp_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
            @(negedge clk_i);
        end
        rdy_mode = 2;
        issue(0, 3'd4, 32'h41, 32'd0, 1, acc);
        chk("bp_accept_edge", 32'(acc), 32'(hs_cyc + 1));
        drain();

        // Back-to-back throughput
        issue(0, 3'd2, 32'h40, 32'd0, 1, prev);
        for (int i = 0; i < 3; i++) begin
            issue(0, 3'd2, 32'h100, 32'd0, 1, acc);
            chk("throughput", 32'(acc - prev), 32'(WS + 2));
            prev = acc;
        end
        drain();
        rdy_mode = 0;

        // Random traffic over an initialised 16-word window plus error addresses
        for (int i = 0; i < 16; i++) issue(1, 3'd2, 32'(4 * i), $urandom, 1, acc);
        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom_range(1));
            f3 = 3'($urandom_range(7));
            case ($urandom_range(9))
                0:       a = $urandom;
                1:       a = 32'h1000 + 32'($urandom_range(63));
                default: a = 32'($urandom_range(63));
            endcase
            issue(wr, f3, a, $urandom, 1, acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
